// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 chunk packer.
package sha256_pkg;

    localparam int CHUNK_W = 512;
    localparam int LEN_W   = 64;
    localparam int LEN_POS = 448;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_LEN,
        ST_EMIT
    } state_t;

    // Mask keeping the top nbits of a word_w-bit word (LSB-aligned); nbits==0 keeps the whole word.
    function automatic logic [63:0] keep_mask(input int nbits, input int word_w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if ((i < word_w) && ((nbits == 0) || (i >= word_w - nbits))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sha256_chunk_packer.sv
// Packs a streamed message into padded SHA-256 512-bit chunks ('1' bit, zero fill, 64-bit length).
module sha256_chunk_packer
    import sha256_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int MAX_CHUNKS = 64,
    parameter int IDX_W      = $clog2(MAX_CHUNKS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [63:0]        msg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    output logic               chunk_valid,
    input  logic               chunk_ready,
    output logic [511:0]       chunk,
    output logic [IDX_W-1:0]   chunk_idx,
    output logic               chunk_last,
    output logic               busy,
    output logic               error
);

    localparam int SHIFT = $clog2(WORD_W);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHUNKS * CHUNK_W - 65);

    state_t             state;
    state_t             next_state;
    state_t             ret;
    state_t             next_ret;
    logic [CHUNK_W-1:0] buffer;
    logic [9:0]         ptr;
    logic [LEN_W-1:0]   words_left;
    logic [LEN_W-1:0]   len;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               error_q;

    logic               len_legal;
    logic               last_word;
    logic [SHIFT-1:0]   rem;
    logic               partial;
    logic [9:0]         adv;
    logic [9:0]         ptr_sum;
    logic [8:0]         wr_pos;
    logic [63:0]        mask_full;
    logic [WORD_W-1:0]  word_kept;

    // Derived datapath values: truncation of the final word and the next write position.
    always_comb begin
        len_legal = (msg_len <= MAX_LEN);
        last_word = (words_left == LEN_W'(1));
        rem       = len[SHIFT-1:0];
        partial   = last_word && (rem != '0);
        adv       = partial ? 10'(rem) : 10'(WORD_W);
        ptr_sum   = ptr + adv;
        wr_pos    = 9'(CHUNK_W - 1) - ptr[8:0];
        mask_full = keep_mask(partial ? int'(rem) : 0, WORD_W);
        word_kept = in_data & mask_full[WORD_W-1:0];
    end

    // State and return-state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            ret   <= ST_IDLE;
        end else begin
            state <= next_state;
            ret   <= next_ret;
        end
    end

    // Next-state selection and handshake/status outputs.
    always_comb begin
        next_state  = state;
        next_ret    = ret;
        in_ready    = 1'b0;
        chunk_valid = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start && len_legal) begin
                    next_state = (msg_len == '0) ? ST_PAD : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (ptr_sum == 10'(CHUNK_W)) begin
                        next_state = ST_EMIT;
                        next_ret   = last_word ? ST_PAD : ST_LOAD;
                    end else if (last_word) begin
                        next_state = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                next_state = ST_EMIT;
                next_ret   = (ptr <= 10'(LEN_POS - 1)) ? ST_IDLE : ST_LEN;
            end
            ST_LEN: begin
                next_state = ST_EMIT;
                next_ret   = ST_IDLE;
            end
            ST_EMIT: begin
                chunk_valid = 1'b1;
                if (chunk_ready) begin
                    next_state = ret;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Chunk buffer, write pointer, word counter, chunk index and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            buffer     <= '0;
            ptr        <= '0;
            words_left <= '0;
            len        <= '0;
            idx        <= '0;
            last       <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!len_legal) begin
                            error_q <= 1'b1;
                        end else begin
                            len        <= msg_len;
                            words_left <= (msg_len + LEN_W'(WORD_W - 1)) >> SHIFT;
                            ptr        <= '0;
                            idx        <= '0;
                            buffer     <= '0;
                            last       <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        buffer[wr_pos -: WORD_W] <= word_kept;
                        ptr        <= ptr_sum;
                        words_left <= words_left - LEN_W'(1);
                    end
                end
                ST_PAD: begin
                    buffer[wr_pos] <= 1'b1;
                    if (ptr <= 10'(LEN_POS - 1)) begin
                        buffer[LEN_W-1:0] <= len;
                        last              <= 1'b1;
                    end
                end
                ST_LEN: begin
                    buffer[LEN_W-1:0] <= len;
                    last              <= 1'b1;
                end
                ST_EMIT: begin
                    if (chunk_ready) begin
                        buffer <= '0;
                        ptr    <= '0;
                        idx    <= idx + IDX_W'(1);
                        last   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign chunk      = buffer;
    assign chunk_idx  = idx;
    assign chunk_last = last;
    assign error      = error_q;

endmodule

// File: tb/tb_sha256_chunk_packer.sv
// Directed self-checking bench for sha256_chunk_packer with hand-computed padded chunks.
module tb_sha256_chunk_packer;

    localparam int WORD_W     = 32;
    localparam int MAX_CHUNKS = 64;
    localparam int IDX_W      = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [63:0]        msg_len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data = '0;
    logic               chunk_valid;
    logic               chunk_ready = 1'b0;
    logic [511:0]       chunk;
    logic [IDX_W-1:0]   chunk_idx;
    logic               chunk_last;
    logic               busy;
    logic               error;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_count     = 0;

    logic [31:0]  words [16];
    logic [511:0] data_vec;
    logic [511:0] got_chunk;
    logic [IDX_W-1:0] got_idx;
    logic         got_last;
    logic [511:0] exp_abc;
    int           hs_base;

    sha256_chunk_packer #(
        .WORD_W(WORD_W),
        .MAX_CHUNKS(MAX_CHUNKS),
        .IDX_W(IDX_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .msg_len(msg_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready),
        .chunk(chunk),
        .chunk_idx(chunk_idx),
        .chunk_last(chunk_last),
        .busy(busy),
        .error(error)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Count every chunk handshake seen on the output side.
    always @(posedge clock) begin
        if (chunk_valid && chunk_ready) hs_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_msg(input logic [63:0] len_bits);
        start   = 1'b1;
        msg_len = len_bits;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check_output("in_ready_timeout", 512'd0, 512'd1);
    endtask

    task automatic get_chunk(output logic [511:0] c, output logic [IDX_W-1:0] i, output logic l);
        bit done;
        done = 1'b0;
        c = '0;
        i = '0;
        l = 1'b0;
        chunk_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (chunk_valid) begin
                c = chunk;
                i = chunk_idx;
                l = chunk_last;
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        chunk_ready = 1'b0;
        if (!done) check_output("chunk_timeout", 512'd0, 512'd1);
    endtask

    task automatic fill_words(input int n);
        data_vec = '0;
        for (int k = 0; k < 16; k++) begin
            words[k] = (k < n) ? $urandom : 32'h0;
            data_vec[511 - 32*k -: 32] = words[k];
        end
    endtask

    // "abc" with junk in the low byte: masking must drop it and latency must include PAD.
    task automatic run_abc(input string tag);
        start_msg(64'd24);
        send_word(32'h616263FF);
        check_output({tag, "_pad_cycle_valid"}, 512'(chunk_valid), 512'd0);
        tick();
        check_output({tag, "_valid_rise"}, 512'(chunk_valid), 512'd1);
        get_chunk(got_chunk, got_idx, got_last);
        check_output({tag, "_chunk"}, got_chunk, exp_abc);
        check_output({tag, "_idx"}, 512'(got_idx), 512'd0);
        check_output({tag, "_last"}, 512'(got_last), 512'd1);
        check_output({tag, "_busy_after"}, 512'(busy), 512'd0);
    endtask

    initial begin
        exp_abc = {32'h61626380, 416'd0, 64'd24};

        tick();
        tick();
        check_output("rst_chunk", chunk, 512'd0);
        check_output("rst_flags", 512'({chunk_valid, in_ready, chunk_last, busy, error}), 512'd0);
        check_output("rst_idx", 512'(chunk_idx), 512'd0);
        reset = 1'b0;
        tick();

        run_abc("abc");

        // Empty message: PAD straight from IDLE, no input words.
        start_msg(64'd0);
        check_output("empty_in_ready", 512'(in_ready), 512'd0);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("empty_chunk", got_chunk, {1'b1, 511'd0});
        check_output("empty_last", 512'(got_last), 512'd1);
        check_output("empty_in_ready_after", 512'(in_ready), 512'd0);

        // L=448: '1' at bit 63, length spills into an extra chunk.
        fill_words(14);
        start_msg(64'd448);
        for (int k = 0; k < 14; k++) send_word(words[k]);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("l448_chunk0", got_chunk, {data_vec[511:64], 1'b1, 63'd0});
        check_output("l448_last0", 512'(got_last), 512'd0);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("l448_chunk1", got_chunk, {448'd0, 64'h1C0});
        check_output("l448_idx1", 512'(got_idx), 512'd1);
        check_output("l448_last1", 512'(got_last), 512'd1);

        // L=447: '1' at bit 64, length fits in the same chunk.
        fill_words(14);
        start_msg(64'd447);
        for (int k = 0; k < 14; k++) send_word(words[k]);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("l447_chunk", got_chunk, {data_vec[511:65], 1'b1, 64'd447});
        check_output("l447_last", 512'(got_last), 512'd1);
        check_output("l447_busy_after", 512'(busy), 512'd0);

        // L=512: data fills one chunk, padding starts a new one.
        fill_words(16);
        start_msg(64'd512);
        for (int k = 0; k < 16; k++) send_word(words[k]);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("l512_chunk0", got_chunk, data_vec);
        check_output("l512_last0", 512'(got_last), 512'd0);
        get_chunk(got_chunk, got_idx, got_last);
        check_output("l512_chunk1", got_chunk, {1'b1, 447'd0, 64'h200});
        check_output("l512_idx1", 512'(got_idx), 512'd1);
        check_output("l512_last1", 512'(got_last), 512'd1);

        // Back-pressure: output held stable for 5 cycles, exactly one handshake.
        hs_base = hs_count;
        start_msg(64'd24);
        send_word(32'h61626300);
        tick();
        for (int k = 0; k < 5; k++) begin
            check_output("bp_valid", 512'(chunk_valid), 512'd1);
            check_output("bp_chunk", chunk, exp_abc);
            check_output("bp_idx", 512'(chunk_idx), 512'd0);
            check_output("bp_in_ready", 512'(in_ready), 512'd0);
            tick();
        end
        get_chunk(got_chunk, got_idx, got_last);
        tick();
        check_output("bp_handshakes", 512'(hs_count - hs_base), 512'd1);

        // Reset in the middle of LOAD discards the partial chunk.
        fill_words(3);
        hs_base = hs_count;
        start_msg(64'd512);
        for (int k = 0; k < 3; k++) send_word(words[k]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("midrst_chunk", chunk, 512'd0);
        check_output("midrst_flags", 512'({chunk_valid, in_ready, chunk_last, busy, error}), 512'd0);
        check_output("midrst_idx", 512'(chunk_idx), 512'd0);
        tick();
        tick();
        check_output("midrst_no_chunk", 512'(hs_count - hs_base), 512'd0);
        run_abc("post_rst_abc");

        // Illegal length: one-cycle error pulse, never busy.
        start_msg(64'(MAX_CHUNKS * 512 - 64));
        check_output("err_pulse", 512'(error), 512'd1);
        check_output("err_busy", 512'(busy), 512'd0);
        tick();
        check_output("err_clear", 512'(error), 512'd0);
        check_output("err_busy_after", 512'(busy), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
